// File: rtl/core_pkg.sv
// Shared core definitions: architectural width, the canonical NOP and the
// fetch packet carried from the fetch stage to decode.
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  // RV32I instruction addresses must be word aligned.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle.
// The slave modport is the queue's view; the master modport is the
// fetch/decode environment driving it.
interface fetch_queue_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush_i;
  logic          f_valid_i;
  logic          f_ready_o;
  logic [31:0]   f_pc_i;
  logic [31:0]   f_instr_i;
  logic          d_valid_o;
  logic          d_ready_i;
  logic [31:0]   d_pc_o;
  logic [31:0]   d_instr_o;
  logic          d_misalign_o;
  logic [CW-1:0] count_o;

  modport slave (
    input  flush_i, f_valid_i, f_pc_i, f_instr_i, d_ready_i,
    output f_ready_o, d_valid_o, d_pc_o, d_instr_o, d_misalign_o, count_o
  );

  modport master (
    output flush_i, f_valid_i, f_pc_i, f_instr_i, d_ready_i,
    input  f_ready_o, d_valid_o, d_pc_o, d_instr_o, d_misalign_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: small FIFO of {pc, instr} pairs between IMEM fetch and decode.
// Registered-only ready on the fetch side, combinational head read on the
// decode side, NOP presented whenever the queue is empty, single-cycle flush.
module fetch_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.slave  bus
);
  import core_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_pkt_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_f_ready;
  logic          w_d_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_en [DEPTH];
  fetch_pkt_t    w_wr_pkt;
  fetch_pkt_t    w_head;

  // Handshake qualifiers; ready depends only on registered occupancy so a
  // same-cycle pop never opens a slot for a push when full.
  assign w_f_ready = (r_count < FULL_CNT);
  assign w_d_valid = (r_count != '0);
  assign w_push    = bus.f_valid_i && w_f_ready;
  assign w_pop     = bus.d_ready_i && w_d_valid;
  assign w_wr_pkt  = '{pc: bus.f_pc_i, instr: bus.f_instr_i};

  // Per-entry write enables; a flush discards the push of that cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign w_wr_en[gi] = w_push && !bus.flush_i && (r_wr_ptr == PW'(gi));
    end
  endgenerate

  // Storage: cleared on reset so decode outputs are never X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_en[i]) begin
          r_mem[i] <= w_wr_pkt;
        end
      end
    end
  end

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Decode-side view: head entry gated by valid, NOP/zero when empty.
  assign w_head           = r_mem[r_rd_ptr];
  assign bus.f_ready_o    = w_f_ready;
  assign bus.d_valid_o    = w_d_valid;
  assign bus.d_pc_o       = w_d_valid ? w_head.pc    : 32'h0;
  assign bus.d_instr_o    = w_d_valid ? w_head.instr : NOP_INSTR;
  assign bus.d_misalign_o = w_d_valid && pc_misaligned(w_head.pc);
  assign bus.count_o      = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based scoreboard tracks the
// expected contents; each scenario task drives stimulus and compares inline.
module tb_fetch_queue;
  import core_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  fetch_pkt_t sb[$];

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: decide push/pop from the model, update the scoreboard,
  // return at the following falling edge where outputs are sampled.
  task automatic tick();
    bit m_push;
    bit m_pop;
    fetch_pkt_t pkt;
    m_push = bus.f_valid_i && (sb.size() < DEPTH);
    m_pop  = bus.d_ready_i && (sb.size() != 0);
    pkt    = '{pc: bus.f_pc_i, instr: bus.f_instr_i};
    @(posedge clk);
    if (bus.flush_i) begin
      sb.delete();
    end else begin
      if (m_pop) void'(sb.pop_front());
      if (m_push) sb.push_back(pkt);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.flush_i   = 1'b0;
    bus.f_valid_i = 1'b0;
    bus.f_pc_i    = 32'h0;
    bus.f_instr_i = 32'h0;
    bus.d_ready_i = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    bus.f_valid_i = 1'b1;
    bus.f_pc_i    = pc;
    bus.f_instr_i = instr;
    bus.d_ready_i = 1'b0;
    tick();
    bus.f_valid_i = 1'b0;
  endtask

  task automatic drain();
    bus.f_valid_i = 1'b0;
    bus.d_ready_i = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    bus.d_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    n_cmp++; if (bus.count_o !== 2'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    n_cmp++; if (bus.f_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_f_ready got=%b exp=1", bus.f_ready_o); end
    n_cmp++; if (bus.d_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_d_valid got=%b exp=0", bus.d_valid_o); end
    n_cmp++; if (bus.d_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_d_pc got=%h exp=0", bus.d_pc_o); end
    n_cmp++; if (bus.d_instr_o !== NOP) begin n_err++; $display("FAIL reset_d_instr got=%h exp=%h", bus.d_instr_o, NOP); end
    n_cmp++; if (bus.d_misalign_o !== 1'b0) begin n_err++; $display("FAIL reset_misalign got=%b exp=0", bus.d_misalign_o); end
    $display("reset: count=%0d d_valid=%b d_instr=%h", bus.count_o, bus.d_valid_o, bus.d_instr_o);
  endtask

  task automatic test_fill_drain();
    push_one(32'h0, 32'h0050_0093);
    push_one(32'h4, 32'h00A0_0113);
    n_cmp++; if (bus.count_o !== 2'd2) begin n_err++; $display("FAIL fill_count got=%0d exp=2", bus.count_o); end
    n_cmp++; if (bus.f_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_f_ready got=%b exp=0", bus.f_ready_o); end
    // third push held off while full
    push_one(32'h8, 32'h00F0_0193);
    n_cmp++; if (bus.count_o !== 2'd2) begin n_err++; $display("FAIL held_count got=%0d exp=2", bus.count_o); end
    n_cmp++; if (bus.d_pc_o !== 32'h0) begin n_err++; $display("FAIL held_head got=%h exp=0", bus.d_pc_o); end
    bus.d_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (bus.d_pc_o !== sb[0].pc || bus.d_instr_o !== sb[0].instr) begin
        n_err++; $display("FAIL drain_head%0d got=%h/%h exp=%h/%h", i, bus.d_pc_o, bus.d_instr_o, sb[0].pc, sb[0].instr);
      end
      $display("drain: pc=%h instr=%h", bus.d_pc_o, bus.d_instr_o);
      tick();
    end
    bus.d_ready_i = 1'b0;
    n_cmp++; if (bus.d_valid_o !== 1'b0 || bus.d_instr_o !== NOP || bus.d_pc_o !== 32'h0) begin
      n_err++; $display("FAIL drain_empty got v=%b pc=%h instr=%h exp v=0 pc=0 instr=%h", bus.d_valid_o, bus.d_pc_o, bus.d_instr_o, NOP);
    end
    n_cmp++; if (bus.count_o !== 2'd0) begin n_err++; $display("FAIL drain_count got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    int pops;
    exp_pc = 32'h0;
    pops = 0;
    bus.d_ready_i = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      bus.f_valid_i = (i < 8);
      bus.f_pc_i    = 32'(i * 4);
      bus.f_instr_i = 32'hA000_0000 | 32'(i * 4);
      n_cmp++; if (bus.d_valid_o !== (sb.size() != 0)) begin n_err++; $display("FAIL stream_valid%0d got=%b exp=%b", i, bus.d_valid_o, sb.size() != 0); end
      if (sb.size() != 0) begin
        n_cmp++; if (bus.d_pc_o !== exp_pc || bus.d_instr_o !== (32'hA000_0000 | exp_pc)) begin
          n_err++; $display("FAIL stream_data got=%h/%h exp=%h/%h", bus.d_pc_o, bus.d_instr_o, exp_pc, 32'hA000_0000 | exp_pc);
        end
        $display("stream: pop pc=%h instr=%h", bus.d_pc_o, bus.d_instr_o);
        exp_pc = exp_pc + 32'h4;
        pops++;
      end
      tick();
      if (i < 8) begin
        n_cmp++; if (bus.count_o !== 2'd1) begin n_err++; $display("FAIL stream_count%0d got=%0d exp=1", i, bus.count_o); end
      end
    end
    idle_inputs();
    n_cmp++; if (pops != 8) begin n_err++; $display("FAIL stream_pops got=%0d exp=8", pops); end
    n_cmp++; if (bus.count_o !== 2'd0) begin n_err++; $display("FAIL stream_end_count got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_full_pop();
    push_one(32'h0, 32'h1111_0000);
    push_one(32'h4, 32'h1111_0004);
    bus.f_valid_i = 1'b1;
    bus.f_pc_i    = 32'h8;
    bus.f_instr_i = 32'h1111_0008;
    bus.d_ready_i = 1'b1;
    tick();
    n_cmp++; if (bus.count_o !== 2'd1) begin n_err++; $display("FAIL fullpop_e1_count got=%0d exp=1", bus.count_o); end
    n_cmp++; if (bus.d_pc_o !== 32'h4) begin n_err++; $display("FAIL fullpop_e1_head got=%h exp=4", bus.d_pc_o); end
    tick();
    bus.f_valid_i = 1'b0;
    bus.d_ready_i = 1'b0;
    n_cmp++; if (bus.count_o !== 2'd1) begin n_err++; $display("FAIL fullpop_e2_count got=%0d exp=1", bus.count_o); end
    n_cmp++; if (bus.d_pc_o !== 32'h8 || bus.d_instr_o !== 32'h1111_0008) begin
      n_err++; $display("FAIL fullpop_head got=%h/%h exp=8/11110008", bus.d_pc_o, bus.d_instr_o);
    end
    $display("fullpop: head pc=%h count=%0d", bus.d_pc_o, bus.count_o);
    drain();
  endtask

  task automatic test_flush();
    push_one(32'h10, 32'h2222_0010);
    push_one(32'h14, 32'h2222_0014);
    bus.flush_i   = 1'b1;
    bus.f_valid_i = 1'b1;
    bus.f_pc_i    = 32'h40;
    bus.f_instr_i = 32'h2222_0040;
    bus.d_ready_i = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (bus.count_o !== 2'd0 || bus.d_valid_o !== 1'b0) begin
      n_err++; $display("FAIL flush_empty got count=%0d v=%b exp count=0 v=0", bus.count_o, bus.d_valid_o);
    end
    push_one(32'h80, 32'h2222_0080);
    n_cmp++; if (bus.count_o !== 2'd1) begin n_err++; $display("FAIL flush_refill_count got=%0d exp=1", bus.count_o); end
    n_cmp++; if (bus.d_pc_o !== 32'h80 || bus.d_instr_o !== 32'h2222_0080) begin
      n_err++; $display("FAIL flush_refill_head got=%h/%h exp=80/22220080", bus.d_pc_o, bus.d_instr_o);
    end
    $display("flush: head pc=%h count=%0d", bus.d_pc_o, bus.count_o);
    drain();
  endtask

  task automatic test_misalign();
    push_one(32'h0000_0102, 32'h3333_0102);
    n_cmp++; if (bus.d_misalign_o !== 1'b1) begin n_err++; $display("FAIL misalign_set got=%b exp=1", bus.d_misalign_o); end
    bus.d_ready_i = 1'b1;
    tick();
    bus.d_ready_i = 1'b0;
    n_cmp++; if (bus.d_misalign_o !== 1'b0) begin n_err++; $display("FAIL misalign_clear got=%b exp=0", bus.d_misalign_o); end
    $display("misalign: after pop misalign=%b valid=%b", bus.d_misalign_o, bus.d_valid_o);
  endtask

  task automatic test_async_reset();
    push_one(32'h20, 32'h4444_0020);
    push_one(32'h24, 32'h4444_0024);
    n_cmp++; if (bus.count_o !== 2'd2) begin n_err++; $display("FAIL arst_pre_count got=%0d exp=2", bus.count_o); end
    #2 rst = 1'b1;
    #1;
    sb.delete();
    n_cmp++; if (bus.count_o !== 2'd0) begin n_err++; $display("FAIL arst_count got=%0d exp=0", bus.count_o); end
    n_cmp++; if (bus.d_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_valid got=%b exp=0", bus.d_valid_o); end
    n_cmp++; if (bus.d_instr_o !== NOP) begin n_err++; $display("FAIL arst_instr got=%h exp=%h", bus.d_instr_o, NOP); end
    n_cmp++; if (bus.f_ready_o !== 1'b1) begin n_err++; $display("FAIL arst_ready got=%b exp=1", bus.f_ready_o); end
    $display("async reset: count=%0d d_instr=%h", bus.count_o, bus.d_instr_o);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_pop();
    test_flush();
    test_misalign();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
